// File: rtl/scan_cross_count.sv
// scan_cross_count: counts stroke edges of a binarized digit along one
// horizontal scan row and four vertical scan columns placed inside the
// digit's bounding box. Counts gathered during one frame are presented
// one cycle after the frame_start that closes it.
module scan_cross_count #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       pix_valid,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       pix_bin,
    input  logic [9:0] box_x_min,
    input  logic [9:0] box_x_max,
    input  logic [9:0] box_y_min,
    input  logic [9:0] box_y_max,
    input  logic       box_valid,
    output logic [3:0] count_x1,
    output logic [3:0] count_y1,
    output logic [3:0] count_y2,
    output logic [3:0] count_y3,
    output logic [3:0] count_y4,
    output logic       count_valid
);

    localparam logic [10:0] H_LIMIT = 11'(H_ACTIVE);
    localparam logic [10:0] V_LIMIT = 11'(V_ACTIVE);

    // Saturating 4-bit add of a 0..2 increment; counters stick at 15.
    function automatic logic [3:0] sat_add(input logic [3:0] a, input logic [1:0] b);
        logic [4:0] t;
        t = {1'b0, a} + {3'b000, b};
        return (t > 5'd15) ? 4'd15 : t[3:0];
    endfunction

    // Frame bookkeeping and latched bounding box.
    logic       first_q, first_d;
    logic       box_ok_q, box_ok_d;
    logic [9:0] x_min_q, x_min_d;
    logic [9:0] x_max_q, x_max_d;
    logic [9:0] y_min_q, y_min_d;
    logic [9:0] y_max_q, y_max_d;

    // Scan positions derived from the latched box.
    logic [9:0] box_w, box_h;
    logic [9:0] row_q, row_d;
    logic [9:0] col_q [4];
    logic [9:0] col_d [4];

    // Working counters and previous-sample bits.
    logic [3:0] cnt_h_q, cnt_h_d;
    logic [3:0] cnt_v_q [4];
    logic [3:0] cnt_v_d [4];
    logic       prev_h_q, prev_h_d;
    logic [3:0] prev_v_q, prev_v_d;

    // Presented results.
    logic [3:0] out_x1_q, out_x1_d;
    logic [3:0] out_y_q [4];
    logic [3:0] out_y_d [4];
    logic       count_valid_q, count_valid_d;

    // Pixel qualification helpers.
    logic       box_accept;
    logic       in_range;
    logic       pix_use;
    logic       in_x, in_y;
    logic       samp;
    logic       prev_h_eff;
    logic [1:0] inc_h;
    logic       prev_v_eff [4];
    logic [1:0] inc_v [4];

    // Scan row and columns, recomputed every cycle from the latched box so
    // they settle one cycle after a new box is captured.
    always_comb begin
        box_w    = x_max_q - x_min_q;
        box_h    = y_max_q - y_min_q;
        row_d    = y_min_q + (box_h >> 1);
        col_d[0] = x_min_q + (box_w >> 1);
        col_d[1] = x_min_q + (box_w >> 2);
        col_d[2] = x_min_q + (box_w >> 1) + (box_w >> 2);
        col_d[3] = x_min_q + (box_w >> 3);
    end

    // Pixel qualification: in the active area, not coincident with
    // frame_start, and only when a box was latched for this frame.
    always_comb begin
        box_accept = box_valid && (box_x_min <= box_x_max) && (box_y_min <= box_y_max);
        in_range   = ({1'b0, pix_x} < H_LIMIT) && ({1'b0, pix_y} < V_LIMIT);
        pix_use    = pix_valid && !frame_start && in_range && box_ok_q;
        in_x       = (pix_x >= x_min_q) && (pix_x <= x_max_q);
        in_y       = (pix_y >= y_min_q) && (pix_y <= y_max_q);
        samp       = pix_bin && in_x && in_y;
    end

    // Edge counting, frame rollover and result presentation.
    always_comb begin
        first_d       = first_q;
        box_ok_d      = box_ok_q;
        x_min_d       = x_min_q;
        x_max_d       = x_max_q;
        y_min_d       = y_min_q;
        y_max_d       = y_max_q;
        cnt_h_d       = cnt_h_q;
        prev_h_d      = prev_h_q;
        prev_v_d      = prev_v_q;
        out_x1_d      = out_x1_q;
        count_valid_d = 1'b0;
        prev_h_eff    = 1'b0;
        inc_h         = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cnt_v_d[k]    = cnt_v_q[k];
            out_y_d[k]    = out_y_q[k];
            prev_v_eff[k] = 1'b0;
            inc_v[k]      = 2'd0;
        end

        if (pix_use && (pix_y == row_q) && in_x) begin
            prev_h_eff = (pix_x == x_min_q) ? 1'b0 : prev_h_q;
            inc_h      = {1'b0, samp ^ prev_h_eff} + {1'b0, samp && (pix_x == x_max_q)};
            cnt_h_d    = sat_add(cnt_h_q, inc_h);
            prev_h_d   = samp;
        end

        for (int k = 0; k < 4; k++) begin
            if (pix_use && (pix_x == col_q[k]) && in_y) begin
                prev_v_eff[k] = (pix_y == y_min_q) ? 1'b0 : prev_v_q[k];
                inc_v[k]      = {1'b0, samp ^ prev_v_eff[k]} + {1'b0, samp && (pix_y == y_max_q)};
                cnt_v_d[k]    = sat_add(cnt_v_q[k], inc_v[k]);
                prev_v_d[k]   = samp;
            end
        end

        if (frame_start) begin
            if (!first_q) begin
                count_valid_d = 1'b1;
                out_x1_d      = box_ok_q ? cnt_h_q : 4'd0;
                for (int k = 0; k < 4; k++) begin
                    out_y_d[k] = box_ok_q ? cnt_v_q[k] : 4'd0;
                end
            end
            first_d  = 1'b0;
            box_ok_d = box_accept;
            x_min_d  = box_x_min;
            x_max_d  = box_x_max;
            y_min_d  = box_y_min;
            y_max_d  = box_y_max;
            cnt_h_d  = 4'd0;
            prev_h_d = 1'b0;
            prev_v_d = 4'd0;
            for (int k = 0; k < 4; k++) begin
                cnt_v_d[k] = 4'd0;
            end
        end
    end

    // State registers; reset leaves the block waiting for a fresh frame.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            first_q       <= 1'b1;
            box_ok_q      <= 1'b0;
            x_min_q       <= '0;
            x_max_q       <= '0;
            y_min_q       <= '0;
            y_max_q       <= '0;
            row_q         <= '0;
            cnt_h_q       <= '0;
            prev_h_q      <= 1'b0;
            prev_v_q      <= '0;
            out_x1_q      <= '0;
            count_valid_q <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                col_q[k]   <= '0;
                cnt_v_q[k] <= '0;
                out_y_q[k] <= '0;
            end
        end else begin
            first_q       <= first_d;
            box_ok_q      <= box_ok_d;
            x_min_q       <= x_min_d;
            x_max_q       <= x_max_d;
            y_min_q       <= y_min_d;
            y_max_q       <= y_max_d;
            row_q         <= row_d;
            cnt_h_q       <= cnt_h_d;
            prev_h_q      <= prev_h_d;
            prev_v_q      <= prev_v_d;
            out_x1_q      <= out_x1_d;
            count_valid_q <= count_valid_d;
            for (int k = 0; k < 4; k++) begin
                col_q[k]   <= col_d[k];
                cnt_v_q[k] <= cnt_v_d[k];
                out_y_q[k] <= out_y_d[k];
            end
        end
    end

    assign count_x1    = out_x1_q;
    assign count_y1    = out_y_q[0];
    assign count_y2    = out_y_q[1];
    assign count_y3    = out_y_q[2];
    assign count_y4    = out_y_q[3];
    assign count_valid = count_valid_q;

endmodule

// File: tb/tb_scan_cross_count.sv
// Directed testbench for scan_cross_count.
module tb_scan_cross_count;

    logic       clock;
    logic       rst_n;
    logic       frame_start;
    logic       pix_valid;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       pix_bin;
    logic [9:0] box_x_min;
    logic [9:0] box_x_max;
    logic [9:0] box_y_min;
    logic [9:0] box_y_max;
    logic       box_valid;
    logic [3:0] count_x1;
    logic [3:0] count_y1;
    logic [3:0] count_y2;
    logic [3:0] count_y3;
    logic [3:0] count_y4;
    logic       count_valid;

    int test_count;
    int fail_count;

    scan_cross_count #(.H_ACTIVE(640), .V_ACTIVE(480)) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_bin     (pix_bin),
        .box_x_min   (box_x_min),
        .box_x_max   (box_x_max),
        .box_y_min   (box_y_min),
        .box_y_max   (box_y_max),
        .box_valid   (box_valid),
        .count_x1    (count_x1),
        .count_y1    (count_y1),
        .count_y2    (count_y2),
        .count_y3    (count_y3),
        .count_y4    (count_y4),
        .count_valid (count_valid)
    );

    // Free-running clock, 10 time units per period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One comparison: counts it, and reports on mismatch.
    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        test_count++;
        assert (got === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Pulse frame_start with a box; optionally put a stroke pixel on the
    // frame_start cycle itself (row 130, column 120).
    task automatic applyStimulus(input logic bv, input int x0, input int x1,
                                 input int y0, input int y1, input logic coinc);
        frame_start = 1'b1;
        box_valid   = bv;
        box_x_min   = 10'(x0);
        box_x_max   = 10'(x1);
        box_y_min   = 10'(y0);
        box_y_max   = 10'(y1);
        pix_valid   = coinc;
        pix_x       = 10'd120;
        pix_y       = 10'd130;
        pix_bin     = coinc;
        tick();
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        pix_bin     = 1'b0;
    endtask

    // Check the presented counts, then that the pulse is one cycle and
    // the outputs hold afterwards. Ends one idle cycle after frame_start.
    task automatic check_frame(input string tag, input int ex1, input int ey1,
                               input int ey2, input int ey3, input int ey4);
        checkOutput({tag, "_valid"}, 8'(count_valid), 8'd1);
        checkOutput({tag, "_x1"}, 8'(count_x1), 8'(ex1));
        checkOutput({tag, "_y1"}, 8'(count_y1), 8'(ey1));
        checkOutput({tag, "_y2"}, 8'(count_y2), 8'(ey2));
        checkOutput({tag, "_y3"}, 8'(count_y3), 8'(ey3));
        checkOutput({tag, "_y4"}, 8'(count_y4), 8'(ey4));
        tick();
        checkOutput({tag, "_pulse_end"}, 8'(count_valid), 8'd0);
        checkOutput({tag, "_hold_x1"}, 8'(count_x1), 8'(ex1));
        checkOutput({tag, "_hold_y1"}, 8'(count_y1), 8'(ey1));
    endtask

    task automatic drive_pixel(input int x, input int y, input logic b);
        pix_valid = 1'b1;
        pix_x     = 10'(x);
        pix_y     = 10'(y);
        pix_bin   = b;
        tick();
        pix_valid = 1'b0;
        pix_bin   = 1'b0;
    endtask

    // Box (100,100)-(140,160) with a vertical bar at x=118..122.
    task automatic frame_bar();
        for (int y = 100; y <= 160; y++)
            for (int x = 100; x <= 140; x++)
                drive_pixel(x, y, (x >= 118) && (x <= 122));
    endtask

    // Solid block of ones over a rectangle.
    task automatic frame_ones(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                drive_pixel(x, y, 1'b1);
    endtask

    // Row 11 alternating 1/0 starting with 1 at x=20, up to x_last.
    task automatic frame_alt(input int x_last);
        for (int x = 20; x <= x_last; x++)
            drive_pixel(x, 11, ((x - 20) % 2) == 0);
    endtask

    initial begin
        test_count  = 0;
        fail_count  = 0;
        rst_n       = 1'b0;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        pix_x       = '0;
        pix_y       = '0;
        pix_bin     = 1'b0;
        box_x_min   = '0;
        box_x_max   = '0;
        box_y_min   = '0;
        box_y_max   = '0;
        box_valid   = 1'b0;

        // Reset state.
        repeat (2) tick();
        checkOutput("rst_valid", 8'(count_valid), 8'd0);
        checkOutput("rst_x1", 8'(count_x1), 8'd0);
        checkOutput("rst_y1", 8'(count_y1), 8'd0);
        checkOutput("rst_y4", 8'(count_y4), 8'd0);
        rst_n = 1'b1;
        tick();

        // First frame_start: latch only, no presentation.
        applyStimulus(1'b1, 100, 140, 100, 160, 1'b0);
        checkOutput("first_fs_valid", 8'(count_valid), 8'd0);
        tick();
        frame_bar();

        // Bar frame result; next frame opens with a coincident stroke pixel.
        applyStimulus(1'b1, 100, 140, 100, 160, 1'b1);
        check_frame("bar", 2, 2, 0, 0, 0);
        frame_bar();

        // Same frame again, coincident pixel must not change anything.
        applyStimulus(1'b1, 0, 7, 0, 7, 1'b0);
        check_frame("coinc", 2, 2, 0, 0, 0);
        frame_ones(0, 7, 0, 7);

        // 8x8 solid block: opening and closing edges on every scan line.
        applyStimulus(1'b1, 20, 59, 10, 12, 1'b0);
        check_frame("block", 2, 2, 2, 2, 2);
        frame_alt(59);

        // Alternating row saturates; C3=48 and C4=24 see a lone 1.
        applyStimulus(1'b0, 0, 7, 0, 7, 1'b0);
        check_frame("sat", 15, 0, 0, 1, 1);
        frame_ones(0, 7, 0, 7);

        // No-box frame from box_valid=0.
        applyStimulus(1'b1, 50, 40, 0, 7, 1'b0);
        check_frame("nobox", 0, 0, 0, 0, 0);
        frame_ones(40, 50, 0, 7);

        // No-box frame from x_min > x_max.
        applyStimulus(1'b1, 0, 7, 0, 7, 1'b0);
        check_frame("badbox", 0, 0, 0, 0, 0);
        frame_ones(0, 7, 0, 7);

        // Block again so the outputs are nonzero before the reset test.
        applyStimulus(1'b1, 20, 59, 10, 12, 1'b0);
        check_frame("block2", 2, 2, 2, 2, 2);
        frame_alt(39);

        // Reset mid-frame clears outputs immediately.
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_x1", 8'(count_x1), 8'd0);
        checkOutput("midrst_y1", 8'(count_y1), 8'd0);
        checkOutput("midrst_valid", 8'(count_valid), 8'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // First frame_start after reset presents nothing.
        applyStimulus(1'b1, 0, 7, 0, 7, 1'b0);
        checkOutput("postrst_fs1_valid", 8'(count_valid), 8'd0);
        checkOutput("postrst_fs1_x1", 8'(count_x1), 8'd0);
        tick();
        frame_ones(0, 7, 0, 7);

        // Second frame_start presents the block counts.
        applyStimulus(1'b1, 0, 7, 0, 7, 1'b0);
        check_frame("postrst", 2, 2, 2, 2, 2);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule

// File: doc/scan_cross_count.md
SCAN_CROSS_COUNT -- requirements
Module: scan_cross_count

Interface
REQ-001 Parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 clock  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 frame_start  input  1  one-cycle pulse marking the start of a frame.
REQ-006 pix_valid  input  1  pix_x, pix_y and pix_bin are valid this cycle.
REQ-007 pix_x  input  10  column of the current pixel; raster order, x fastest.
REQ-008 pix_y  input  10  row of the current pixel.
REQ-009 pix_bin  input  1  binarized pixel; 1 = digit stroke, 0 = background.
REQ-010 box_x_min, box_x_max, box_y_min, box_y_max  input  10 each  digit bounding box, inclusive.
REQ-011 box_valid  input  1  bounding box inputs are meaningful.
REQ-012 count_x1  output  4  edge count along the horizontal scan row.
REQ-013 count_y1..count_y4  output  4 each  edge counts along vertical scan columns 1..4.
REQ-014 count_valid  output  1  one-cycle pulse when new counts are presented.

Function
REQ-015 At frame_start with box_valid=1 and min<=max on both axes, latch the box; otherwise mark the frame "no box".
REQ-016 Scan positions, with W=x_max-x_min, H=y_max-y_min and registered one cycle after the latch: row R=y_min+(H>>1); C1=x_min+(W>>1); C2=x_min+(W>>2); C3=x_min+(W>>1)+(W>>2); C4=x_min+(W>>3).
REQ-017 Upstream guarantees the first pix_valid arrives at least 2 cycles after frame_start; pixels coincident with frame_start are ignored.
REQ-018 Sample s = pix_bin AND pixel inside the latched box; pixels outside the box are background.
REQ-019 Horizontal count: on pixels with pix_y==R and x in [x_min,x_max], compare s with prev_h; add 1 when they differ.
REQ-019a prev_h is forced to 0 before comparing at x==x_min.
REQ-019b At x==x_max, add a further 1 when s==1 (closing edge); up to +2 in one cycle.
REQ-020 Vertical count k: on pixels with pix_x==Ck and y in [y_min,y_max], apply the same rule, using prev_vk (one bit per column) and forcing prev_vk to 0 at y==y_min.
REQ-020a Vertical count k adds the closing edge at y==y_max when s==1.
REQ-021 Where scan columns coincide (small W), each counter operates independently on the same pixel.
REQ-022 All working counters are 4-bit and saturate at 15; no wrap-around.
REQ-023 On each frame_start after the first since reset, copy the working counters to the outputs one cycle later and pulse count_valid for one cycle.
REQ-023a On every frame_start, clear the working counters and the prev bits.
REQ-024 A "no box" frame presents all counts 0 at its closing frame_start.
REQ-025 The first frame_start after reset only clears and latches; it presents no count_valid.
REQ-026 Between count_valid pulses, outputs hold their values.
REQ-027 Pixels with pix_x>=H_ACTIVE or pix_y>=V_ACTIVE are ignored.

Reset
REQ-028 While rst_n=0: all counts 0, count_valid 0, working counters and prev bits 0, box marked "no box", first-frame flag set.
REQ-029 Reset deasserted mid-frame: discard the partial frame; nothing is presented until two frame_start pulses have occurred.

Verification
REQ-030 Box (100,100)-(140,160), vertical bar at x=118..122, all rows in box -> count_x1=2, count_y1=2 (C1=120), count_y2=0, count_y3=0, count_y4=0, count_valid one cycle after the next frame_start.
REQ-031 Box (0,0)-(7,7), all pixels 1 -> count_x1=2, count_y1..count_y4=2 each, including the closing edges at x_max and y_max.
REQ-032 Row R alternating 1/0 on each pixel over a 40-pixel box -> count_x1 saturates at 15.
REQ-033 frame_start with box_valid=0, or with x_min>x_max -> all counts 0 at the next count_valid.
REQ-034 rst_n pulsed low mid-frame -> outputs 0 immediately; the first count_valid appears only at the second frame_start after reset.
REQ-035 pix_valid asserted in the same cycle as frame_start with pix_bin=1 on row R -> the pixel is ignored; counts are unchanged versus the same frame without it.
